// File: rtl/vga_frame_reader_pkg.sv
// Shared constants and types for the 640x480 VGA scan-out of the 320x240 frame buffer.
package vga_frame_reader_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned FB_W   = 320;
  localparam int unsigned FB_H   = 240;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned X_W    = 9;
  localparam int unsigned Y_W    = 8;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned BAR_PX = 80;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Control bits that travel alongside the frame-buffer read.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic first;
  } vga_ctl_t;

  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] h);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h >= CNT_W'(i * BAR_PX)) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic rgb444_t bar_color(input logic [2:0] idx);
    rgb444_t c;
    case (idx)
      3'd0:    c = rgb444_t'(12'hFFF);
      3'd1:    c = rgb444_t'(12'hFF0);
      3'd2:    c = rgb444_t'(12'h0FF);
      3'd3:    c = rgb444_t'(12'h0F0);
      3'd4:    c = rgb444_t'(12'hF0F);
      3'd5:    c = rgb444_t'(12'hF00);
      3'd6:    c = rgb444_t'(12'h00F);
      default: c = rgb444_t'(12'h000);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical scan counters with combinational active/hsync/vsync decode.
module vga_timing_gen
  import vga_frame_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt,
  output logic             o_active_c,
  output logic             o_hs_c,
  output logic             o_vs_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == CNT_W'(H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  assign o_h_cnt    = r_h_cnt;
  assign o_v_cnt    = r_v_cnt;
  assign o_active_c = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
  assign o_hs_c     = (r_h_cnt >= CNT_W'(H_ACTIVE + H_FP)) &&
                      (r_h_cnt <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vs_c     = (r_v_cnt >= CNT_W'(V_ACTIVE + V_FP)) &&
                      (r_v_cnt <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_frame_reader.sv
// VGA scan-out: 2x-replicated frame-buffer addressing plus sync/blank realignment.
// Optional colour-bar generator enabled by VGA_FRAME_READER_TEST_PATTERN_EN.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RGB_W-1:0]  i_fb_rdata,
  input  logic              i_pattern_sel,
  output logic [ADDR_W-1:0] o_pixel_addr,
  output logic              o_addr_valid,
  output logic [RGB_W-1:0]  o_pixel_out,
  output logic              o_de,
  output logic              o_hsync_n,
  output logic              o_vsync_n,
  output logic              o_vsync,
  output logic              o_frame_start
);

  localparam int unsigned PIPE_D = RD_LAT + 2;

  logic [CNT_W-1:0]  w_h_cnt;
  logic [CNT_W-1:0]  w_v_cnt;
  logic              w_active;
  logic              w_hs;
  logic              w_vs;
  vga_ctl_t          w_ctl;
  rgb444_t           w_pix_next;

  logic [ADDR_W-1:0] r_pixel_addr;
  logic              r_addr_valid;
  rgb444_t           r_pixel_out;
  vga_ctl_t          r_pipe [PIPE_D];

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_h_cnt    (w_h_cnt),
    .o_v_cnt    (w_v_cnt),
    .o_active_c (w_active),
    .o_hs_c     (w_hs),
    .o_vs_c     (w_vs)
  );

  always_comb begin
    w_ctl        = '0;
    w_ctl.active = w_active;
    w_ctl.hs     = w_hs;
    w_ctl.vs     = w_vs;
    w_ctl.first  = w_active && (w_h_cnt == '0) && (w_v_cnt == '0);
  end

  // Halving both counters replicates each source pixel 2x2 on screen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_addr <= '0;
      r_addr_valid <= 1'b0;
    end else begin
      r_addr_valid <= w_active;
      r_pixel_addr <= w_active ? {w_v_cnt[Y_W:1], w_h_cnt[X_W:1]} : '0;
    end
  end

  // Control delay matches address register + read latency + output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PIPE_D); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_ctl;
      for (int i = 1; i < int'(PIPE_D); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

`ifdef VGA_FRAME_READER_TEST_PATTERN_EN
  logic [2:0] r_bar_pipe [PIPE_D];
  logic       w_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PIPE_D); i++) r_bar_pipe[i] <= '0;
    end else begin
      r_bar_pipe[0] <= bar_index(w_h_cnt);
      for (int i = 1; i < int'(PIPE_D); i++) r_bar_pipe[i] <= r_bar_pipe[i-1];
    end
  end

  assign w_unused = ^{w_h_cnt[0], w_v_cnt[0], w_v_cnt[CNT_W-1], r_bar_pipe[PIPE_D-1]};

  always_comb begin
    w_pix_next = '0;
    if (r_pipe[PIPE_D-2].active) begin
      w_pix_next = i_pattern_sel ? bar_color(r_bar_pipe[PIPE_D-2]) : rgb444_t'(i_fb_rdata);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{w_h_cnt[0], w_v_cnt[0], w_v_cnt[CNT_W-1], i_pattern_sel};

  // Blanking is forced here rather than trusting RAM contents.
  always_comb begin
    w_pix_next = '0;
    if (r_pipe[PIPE_D-2].active) w_pix_next = rgb444_t'(i_fb_rdata);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pixel_out <= '0;
    else        r_pixel_out <= w_pix_next;
  end

  assign o_pixel_addr  = r_pixel_addr;
  assign o_addr_valid  = r_addr_valid;
  assign o_pixel_out   = r_pixel_out;
  assign o_de          = r_pipe[PIPE_D-1].active;
  assign o_hsync_n     = ~r_pipe[PIPE_D-1].hs;
  assign o_vsync_n     = ~r_pipe[PIPE_D-1].vs;
  assign o_vsync       = r_pipe[PIPE_D-1].vs;
  assign o_frame_start = r_pipe[PIPE_D-1].first;

endmodule
